// File: rtl/instr_queue.sv
// In-order queue of decoded control words between the decoder and dispatch, with flush.
// Define IQ_BYPASS_EN to let an enqueue into an empty queue reach head_word in the same cycle.

package tomasulo_types;
    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word;
endpackage

module instr_queue
    import tomasulo_types::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_iq,
    input  ctl_word                  control_word,
    output logic                     iq_resp,
    input  logic                     deq,
    input  logic                     flush,
    output ctl_word                  head_word,
    output logic                     head_valid,
    output logic                     iq_full,
    output logic                     iq_empty,
    output logic [$clog2(DEPTH):0]   iq_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    cnt_t    count_q, count_d;
    ctl_word mem [DEPTH];

    logic acc;
    logic pop;
    logic byp_thru;
    logic wr_en;
    logic rd_adv;
`ifdef IQ_BYPASS_EN
    logic byp;
`endif

    always_comb begin
        iq_empty = (count_q == '0);
        iq_full  = (count_q == cnt_t'(DEPTH));
        iq_count = count_q;
`ifdef IQ_BYPASS_EN
        byp        = iq_empty && ld_iq && !flush;
        head_valid = !iq_empty || byp;
        head_word  = byp ? control_word : mem[rd_ptr_q];
        byp_thru   = byp && deq;
`else
        head_valid = !iq_empty;
        head_word  = mem[rd_ptr_q];
        byp_thru   = 1'b0;
`endif
        // Reset drops the request, so it must not be acknowledged either.
        acc     = ld_iq && !flush && !rst && (!iq_full || (deq && head_valid));
        iq_resp = acc;
        pop     = deq && head_valid && !flush;
        // A word passed straight through to dispatch never touches storage.
        wr_en   = acc && !byp_thru;
        rd_adv  = pop && !byp_thru;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        case ({wr_en, rd_adv})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= control_word;
        end
    end

endmodule
